// File: rtl/camera_pkg.sv
`default_nettype none
// ============================================================================
// Module      : camera_pkg
// Description : Shared definitions for the camera transmit path: frame phase
//               enumeration, byte-lane order of a YCbCr422 pixel pair, default
//               frame geometry and small elaboration helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package camera_pkg;

    // Frame phases, explicitly 3 bits wide
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFRONT = 3'd4
    } cam_state_e;

    // Frame-buffer address width (covers 640x480 / 2 pixel pairs)
    localparam int c_ADDR_W = 19;

    // Default geometry (VGA-style frame)
    localparam int c_DEF_PAIRS_PER_LINE = 320;
    localparam int c_DEF_LINES          = 480;
    localparam int c_DEF_H_BLANK        = 288;
    localparam int c_DEF_VSYNC_LINES    = 3;
    localparam int c_DEF_V_BACK_LINES   = 17;
    localparam int c_DEF_V_FRONT_LINES  = 10;

    // Byte position within a line modulo 4 -> lane of the 32-bit pair word
    localparam logic [1:0] c_LANE_Y0 = 2'd0;  // word[31:24]
    localparam logic [1:0] c_LANE_CB = 2'd1;  // word[23:16]
    localparam logic [1:0] c_LANE_CR = 2'd2;  // word[15:8]
    localparam logic [1:0] c_LANE_Y1 = 2'd3;  // word[7:0]

    function automatic logic [7:0] lane_byte(input logic [31:0] word,
                                             input logic [1:0]  lane);
        logic [7:0] b;
        case (lane)
            c_LANE_Y0: b = word[31:24];
            c_LANE_CB: b = word[23:16];
            c_LANE_CR: b = word[15:8];
            default:   b = word[7:0];
        endcase
        return b;
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/camera_timing.sv
`default_nettype none
// ============================================================================
// Module      : camera_timing
// Description : Frame/line timing generator. Walks IDLE -> VSYNC -> VBACK ->
//               ACTIVE -> VFRONT with every line LINE_LEN cycles long and
//               produces registered vsync/href/frame_done. Also exposes the
//               current and next phase/byte position so the datapath can
//               prepare registered data aligned with href.
// Ports       : clk, rst           - clock, async active-high reset
//               i_enable           - request continuous frames
//               o_state, o_byte    - current phase and byte-in-line counter
//               o_nxt_state/byte   - values they take at the next edge
//               o_nxt_href         - href value that the next edge will load
//               o_vsync, o_href    - registered sync outputs
//               o_frame_done       - one-cycle pulse after the last VFRONT cycle
// Revision    : 1.0 - initial release
// ============================================================================
module camera_timing
    import camera_pkg::*;
#(
    parameter int PAIRS_PER_LINE = c_DEF_PAIRS_PER_LINE,
    parameter int LINES          = c_DEF_LINES,
    parameter int H_BLANK        = c_DEF_H_BLANK,
    parameter int VSYNC_LINES    = c_DEF_VSYNC_LINES,
    parameter int V_BACK_LINES   = c_DEF_V_BACK_LINES,
    parameter int V_FRONT_LINES  = c_DEF_V_FRONT_LINES,
    localparam int c_BYTE_W      = $clog2(4*PAIRS_PER_LINE + H_BLANK)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_enable,
    output cam_state_e          o_state,
    output logic [c_BYTE_W-1:0] o_byte,
    output cam_state_e          o_nxt_state,
    output logic [c_BYTE_W-1:0] o_nxt_byte,
    output logic                o_nxt_href,
    output logic                o_vsync,
    output logic                o_href,
    output logic                o_frame_done
);

    localparam int c_ACT_LEN  = 4*PAIRS_PER_LINE;
    localparam int c_LINE_LEN = c_ACT_LEN + H_BLANK;
    localparam int c_LINE_W   = $clog2(max4(VSYNC_LINES, V_BACK_LINES, LINES, V_FRONT_LINES) + 1);

    localparam logic [c_BYTE_W-1:0] c_LAST_BYTE = c_BYTE_W'(c_LINE_LEN - 1);
    localparam logic [c_BYTE_W-1:0] c_ACT_BYTES = c_BYTE_W'(c_ACT_LEN);
    localparam logic [c_LINE_W-1:0] c_VS_LAST   = c_LINE_W'(VSYNC_LINES - 1);
    localparam logic [c_LINE_W-1:0] c_VB_LAST   = c_LINE_W'(V_BACK_LINES - 1);
    localparam logic [c_LINE_W-1:0] c_ACT_LAST  = c_LINE_W'(LINES - 1);
    localparam logic [c_LINE_W-1:0] c_VF_LAST   = c_LINE_W'(V_FRONT_LINES - 1);

    cam_state_e          r_state;
    logic [c_BYTE_W-1:0] r_byte;
    logic [c_LINE_W-1:0] r_line;
    logic                r_vsync;
    logic                r_href;
    logic                r_frame_done;

    cam_state_e          w_nxt_state;
    logic [c_BYTE_W-1:0] w_nxt_byte;
    logic [c_LINE_W-1:0] w_nxt_line;
    logic                w_line_end;
    logic                w_phase_last;
    logic                w_vsync_d;
    logic                w_href_d;
    logic                w_done_d;

    // State register: phase, counters and the registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_byte       <= '0;
            r_line       <= '0;
            r_vsync      <= 1'b0;
            r_href       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_byte       <= w_nxt_byte;
            r_line       <= w_nxt_line;
            r_vsync      <= w_vsync_d;
            r_href       <= w_href_d;
            r_frame_done <= w_done_d;
        end
    end

    // Next-state logic
    always_comb begin
        w_line_end   = (r_byte == c_LAST_BYTE);
        w_phase_last = 1'b0;
        case (r_state)
            ST_VSYNC:  w_phase_last = (r_line == c_VS_LAST);
            ST_VBACK:  w_phase_last = (r_line == c_VB_LAST);
            ST_ACTIVE: w_phase_last = (r_line == c_ACT_LAST);
            ST_VFRONT: w_phase_last = (r_line == c_VF_LAST);
            default:   w_phase_last = 1'b0;
        endcase

        w_nxt_state = r_state;
        w_nxt_byte  = r_byte + 1'b1;
        w_nxt_line  = r_line;

        if (r_state == ST_IDLE) begin
            w_nxt_byte = '0;
            w_nxt_line = '0;
            if (i_enable) begin
                w_nxt_state = ST_VSYNC;
            end
        end else if (w_line_end) begin
            w_nxt_byte = '0;
            if (w_phase_last) begin
                w_nxt_line = '0;
                case (r_state)
                    ST_VSYNC:  w_nxt_state = ST_VBACK;
                    ST_VBACK:  w_nxt_state = ST_ACTIVE;
                    ST_ACTIVE: w_nxt_state = ST_VFRONT;
                    // enable is only looked at on frame boundaries, so a
                    // mid-frame drop lets the current frame finish
                    ST_VFRONT: w_nxt_state = i_enable ? ST_VSYNC : ST_IDLE;
                    default:   w_nxt_state = ST_IDLE;
                endcase
            end else begin
                w_nxt_line = r_line + 1'b1;
            end
        end
    end

    // Output logic: decode the values the output registers load next, so the
    // outputs change on the same edge as the phase/byte position they belong to
    always_comb begin
        w_vsync_d = (w_nxt_state == ST_VSYNC);
        w_href_d  = (w_nxt_state == ST_ACTIVE) && (w_nxt_byte < c_ACT_BYTES);
        w_done_d  = (r_state == ST_VFRONT) && w_line_end && w_phase_last;
    end

    assign o_state      = r_state;
    assign o_byte       = r_byte;
    assign o_nxt_state  = w_nxt_state;
    assign o_nxt_byte   = w_nxt_byte;
    assign o_nxt_href   = w_href_d;
    assign o_vsync      = r_vsync;
    assign o_href       = r_href;
    assign o_frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: rtl/camera_tx.sv
`default_nettype none
// ============================================================================
// Module      : camera_tx
// Description : Camera-style byte-stream transmitter. Reads YCbCr422 pixel
//               pairs from a frame buffer and drives them one byte per pclk
//               (Y0, Cb, Cr, Y1) with vsync/href framing.
// Ports       : pclk, reset  - clock, async active-high reset
//               enable       - request continuous frame transmission
//               rd_addr      - registered frame-buffer word address
//               rd_data      - frame-buffer word, valid 1 cycle after rd_addr
//               vsync, href  - registered framing outputs
//               data_out     - registered byte stream, 0 while href is low
//               frame_done   - one-cycle pulse at the end of each frame
//               busy         - high whenever not idle
// Revision    : 1.0 - initial release
// ============================================================================
module camera_tx
    import camera_pkg::*;
#(
    parameter int PAIRS_PER_LINE = c_DEF_PAIRS_PER_LINE,
    parameter int LINES          = c_DEF_LINES,
    parameter int H_BLANK        = c_DEF_H_BLANK,
    parameter int VSYNC_LINES    = c_DEF_VSYNC_LINES,
    parameter int V_BACK_LINES   = c_DEF_V_BACK_LINES,
    parameter int V_FRONT_LINES  = c_DEF_V_FRONT_LINES
) (
    input  logic                pclk,
    input  logic                reset,
    input  logic                enable,
    output logic [c_ADDR_W-1:0] rd_addr,
    input  logic [31:0]         rd_data,
    output logic                vsync,
    output logic                href,
    output logic [7:0]          data_out,
    output logic                frame_done,
    output logic                busy
);

    localparam int c_ACT_LEN = 4*PAIRS_PER_LINE;
    localparam int c_BYTE_W  = $clog2(c_ACT_LEN + H_BLANK);

    localparam logic [c_BYTE_W-1:0] c_ACT_BYTES   = c_BYTE_W'(c_ACT_LEN);
    localparam logic [c_BYTE_W-1:0] c_LAST_ACT_Y1 = c_BYTE_W'(c_ACT_LEN - 1);

    cam_state_e          w_state;
    cam_state_e          w_nxt_state;
    logic [c_BYTE_W-1:0] w_byte;
    logic [c_BYTE_W-1:0] w_nxt_byte;
    logic                w_nxt_href;
    logic                w_cap;
    logic                w_vs_entry;
    logic [31:0]         w_src;
    logic [7:0]          w_data_d;

    logic [c_ADDR_W-1:0] r_rd_addr;
    logic [31:0]         r_hold;
    logic [7:0]          r_data;

    camera_timing #(
        .PAIRS_PER_LINE (PAIRS_PER_LINE),
        .LINES          (LINES),
        .H_BLANK        (H_BLANK),
        .VSYNC_LINES    (VSYNC_LINES),
        .V_BACK_LINES   (V_BACK_LINES),
        .V_FRONT_LINES  (V_FRONT_LINES)
    ) u_timing (
        .clk          (pclk),
        .rst          (reset),
        .i_enable     (enable),
        .o_state      (w_state),
        .o_byte       (w_byte),
        .o_nxt_state  (w_nxt_state),
        .o_nxt_byte   (w_nxt_byte),
        .o_nxt_href   (w_nxt_href),
        .o_vsync      (vsync),
        .o_href       (href),
        .o_frame_done (frame_done)
    );

    // A word is captured in the cycle just before each Y0 byte goes out: the
    // last blanking cycle ahead of an active line, or a Y1 cycle that is
    // followed by another pair in the same line.
    assign w_cap = ((w_nxt_state == ST_ACTIVE) && (w_nxt_byte == '0)) ||
                   ((w_state == ST_ACTIVE) && (w_byte < c_ACT_BYTES) &&
                    (w_byte[1:0] == c_LANE_Y1) && (w_byte != c_LAST_ACT_Y1));

    assign w_vs_entry = (w_nxt_state == ST_VSYNC) && (w_state != ST_VSYNC);

    // Y0 leaves on the same edge that loads the hold register, so it is taken
    // straight from rd_data; the remaining lanes come from the hold register.
    assign w_src    = w_cap ? rd_data : r_hold;
    assign w_data_d = w_nxt_href ? lane_byte(w_src, w_nxt_byte[1:0]) : 8'd0;

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            r_rd_addr <= '0;
            r_hold    <= '0;
            r_data    <= '0;
        end else begin
            r_data <= w_data_d;
            if (w_cap) begin
                r_hold <= rd_data;
            end
            if (w_vs_entry) begin
                r_rd_addr <= '0;
            end else if (w_cap) begin
                r_rd_addr <= r_rd_addr + 1'b1;
            end
        end
    end

    assign rd_addr  = r_rd_addr;
    assign data_out = r_data;
    assign busy     = (w_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_camera_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_camera_tx
// Description : Self-checking bench for camera_tx with a small frame geometry.
//               A frame-time reference model predicts every output on every
//               cycle; directed checks cover framing latencies, byte order,
//               enable drop and an asynchronous reset pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_camera_tx;

    localparam int P     = 2;
    localparam int L     = 2;
    localparam int HB    = 4;
    localparam int VSL   = 1;
    localparam int VBL   = 1;
    localparam int VFL   = 1;
    localparam int ACT   = 4*P;
    localparam int LL    = ACT + HB;
    localparam int FRAME = (VSL + VBL + L + VFL) * LL;
    localparam int FIRST_ACT_LINE = VSL + VBL;

    logic        pclk   = 1'b0;
    logic        reset  = 1'b1;
    logic        enable = 1'b0;
    logic [18:0] rd_addr;
    logic [31:0] rd_data = 32'd0;
    logic        vsync;
    logic        href;
    logic [7:0]  data_out;
    logic        frame_done;
    logic        busy;

    logic [31:0] mem [0:7];

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    camera_tx #(
        .PAIRS_PER_LINE (P),
        .LINES          (L),
        .H_BLANK        (HB),
        .VSYNC_LINES    (VSL),
        .V_BACK_LINES   (VBL),
        .V_FRONT_LINES  (VFL)
    ) dut (
        .pclk       (pclk),
        .reset      (reset),
        .enable     (enable),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .vsync      (vsync),
        .href       (href),
        .data_out   (data_out),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 pclk = ~pclk;

    // Frame buffer with one cycle of read latency
    always @(posedge pclk) rd_data <= mem[rd_addr[2:0]];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (frame time index) ----------------
    function automatic bit exp_href(input int t);
        int ln;
        ln = t / LL;
        return (ln >= FIRST_ACT_LINE) && (ln < FIRST_ACT_LINE + L) && ((t % LL) < ACT);
    endfunction

    function automatic bit is_y0(input int t);
        return exp_href(t) && (((t % LL) % 4) == 0);
    endfunction

    function automatic logic [7:0] exp_byte(input int t);
        int          k;
        int          b;
        logic [31:0] w;
        if (!exp_href(t)) return 8'd0;
        b = t % LL;
        k = (t / LL - FIRST_ACT_LINE) * P + b / 4;
        w = mem[k];
        return w[31 - 8*(b % 4) -: 8];
    endfunction

    bit m_run  = 1'b0;
    bit m_done = 1'b0;
    int m_t    = 0;
    int m_addr = 0;

    always @(posedge pclk or posedge reset) begin
        if (reset) begin
            m_run  <= 1'b0;
            m_done <= 1'b0;
            m_t    <= 0;
            m_addr <= 0;
        end else if (!m_run) begin
            m_done <= 1'b0;
            if (enable) begin
                m_run  <= 1'b1;
                m_t    <= 0;
                m_addr <= 0;
            end
        end else if (m_t == FRAME - 1) begin
            m_done <= 1'b1;
            m_t    <= 0;
            m_run  <= enable;
            if (enable) m_addr <= 0;
        end else begin
            m_done <= 1'b0;
            m_t    <= m_t + 1;
            if (is_y0(m_t + 1)) m_addr <= m_addr + 1;
        end
    end

    // ---------------- per-cycle comparison against the model ----------------
    logic [18:0] prev_addr = 19'd0;
    int          run_len   = 0;

    always @(negedge pclk) begin
        if (chk_on) begin
            check_eq("vsync",      vsync,      m_run && (m_t < VSL*LL));
            check_eq("href",       href,       m_run && exp_href(m_t));
            check_eq("data_out",   data_out,   m_run ? exp_byte(m_t) : 8'd0);
            check_eq("frame_done", frame_done, m_done);
            check_eq("busy",       busy,       m_run);
            check_eq("rd_addr",    rd_addr,    m_addr);
            if (rd_addr == prev_addr + 19'd1)
                check_eq("addr_stable_ge4", run_len >= 4, 1);
            if (rd_addr != prev_addr) begin
                prev_addr <= rd_addr;
                run_len   <= 1;
            end else begin
                run_len <= run_len + 1;
            end
        end
    end

    // Advance to just after the next falling edge (inputs change here)
    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge pclk);
            #1;
        end
    endtask

    initial begin
        int         c_vs;
        int         c_hr;
        int         c_fd;
        int         vs_cnt;
        int         fd_cnt;
        bit         vs_at_fd;
        bit         found;
        logic [7:0] q[$];
        logic [7:0] exp_l0 [0:7];
        logic [7:0] exp_l1 [0:3];

        exp_l0 = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h11, 8'h22, 8'h33, 8'h01};
        exp_l1 = '{8'h11, 8'h22, 8'h33, 8'h03};
        for (int k = 0; k < 8; k++) mem[k] = 32'h1122_3300 + k;

        // Reset state
        cyc(3);
        chk_on = 1'b1;
        check_eq("rst_rd_addr", rd_addr, 0);
        check_eq("rst_data", data_out, 0);
        check_eq("rst_vsync", vsync, 0);
        check_eq("rst_busy", busy, 0);

        // Continuous frames from reset release
        reset  = 1'b0;
        enable = 1'b1;
        c_vs = -1; c_hr = -1; c_fd = -1; vs_cnt = 0; vs_at_fd = 1'b0;
        for (int c = 0; c < FRAME + 20; c++) begin
            cyc(1);
            if (vsync && c_vs < 0) c_vs = c;
            if (href && c_hr < 0) c_hr = c;
            if (frame_done && c_fd < 0) begin
                c_fd     = c;
                vs_at_fd = vsync;
            end
            if (vsync && c_fd < 0) vs_cnt++;
            if (href && c_fd < 0) q.push_back(data_out);
        end
        check_eq("vsync_entry_cycle", c_vs, 0);
        check_eq("vsync_len", vs_cnt, VSL*LL);
        check_eq("href_rise_offset", c_hr - c_vs, 24);
        check_eq("frame_done_offset", c_fd - c_vs, 60);
        check_eq("next_vsync_immediate", vs_at_fd, 1);
        check_eq("active_byte_count", q.size(), L*ACT);
        if (q.size() == L*ACT) begin
            for (int i = 0; i < 8; i++) check_eq("line0_byte", q[i], exp_l0[i]);
            for (int i = 0; i < 4; i++) check_eq("line1_tail", q[12+i], exp_l1[i]);
        end

        // Enable dropped during the first active line of the next frame
        found = 1'b0;
        for (int c = 0; c < 2*FRAME && !found; c++) begin
            cyc(1);
            if (href) found = 1'b1;
        end
        check_eq("wait_href", found, 1);
        enable = 1'b0;
        fd_cnt = 0;
        for (int c = 0; c < FRAME + 10; c++) begin
            cyc(1);
            if (frame_done) fd_cnt++;
        end
        check_eq("drop_frame_done_count", fd_cnt, 1);
        check_eq("drop_idle_busy", busy, 0);
        check_eq("drop_idle_vsync", vsync, 0);

        // Randomized runs: random frame contents, random enable patterns
        for (int it = 0; it < 6; it++) begin
            reset = 1'b1;
            cyc(2);
            for (int k = 0; k < 8; k++) mem[k] = $urandom;
            reset  = 1'b0;
            enable = 1'b1;
            if (it % 2 == 0) begin
                cyc($urandom_range(1, 3*FRAME));
            end else begin
                for (int c = 0; c < 3*FRAME; c++) begin
                    enable = ($urandom_range(0, 3) != 0);
                    cyc(1);
                end
            end
            enable = 1'b0;
            cyc(FRAME + 5);
            check_eq("rand_idle_busy", busy, 0);
        end

        // Asynchronous reset pulse between edges in the middle of ACTIVE
        enable = 1'b1;
        found  = 1'b0;
        for (int c = 0; c < 2*FRAME && !found; c++) begin
            cyc(1);
            if (href) found = 1'b1;
        end
        check_eq("wait_href_rst", found, 1);
        cyc(2);
        reset = 1'b1;
        #1;
        check_eq("arst_vsync", vsync, 0);
        check_eq("arst_href", href, 0);
        check_eq("arst_data", data_out, 0);
        check_eq("arst_rd_addr", rd_addr, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_frame_done", frame_done, 0);
        #1;
        reset = 1'b0;
        cyc(1);
        check_eq("restart_vsync", vsync, 1);
        check_eq("restart_rd_addr", rd_addr, 0);
        check_eq("restart_busy", busy, 1);
        cyc(FRAME + 10);
        enable = 1'b0;
        cyc(FRAME + 5);

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
